handshake_sync_bank: RTL and testbench
======================================

# handshake_sync_bank

Parametrised multi-channel handshake synchroniser for the ready/accept control path between loosely coupled power-domain blocks. Each channel brings an asynchronous ready level and accept level into the `clk` domain through a configurable-depth synchroniser. It generates a selectable-edge accept pulse and tracks every ready-to-accept transaction with a per-channel state machine that reports busy, timeout and stray-accept conditions. This block is the general replacement for fixed two-signal bridges wherever more than one channel or supervision is needed.

## Interface
- `NUM_CH`, 4, number of independent channels (1..32)
- `SYNC_STAGES`, 2, synchroniser flops per input bit (legal 2..4)
- `PULSE_MODE`, 0, accept event edge: 0 = rising, 1 = falling, 2 = both
- `TIMEOUT_W`, 8, width of the timeout counter and limit

- `clk` in 1: single clock; all logic is on its rising edge
- `rst` in 1: synchronous, active-high reset
- `rdy_in` in NUM_CH: asynchronous ready levels, one per channel
- `acpt_in` in NUM_CH: asynchronous accept levels, one per channel
- `timeout_limit` in TIMEOUT_W: quasi-static cycle limit shared by all channels; 0 disables timeouts
- `rdy_out` out NUM_CH: synchronised ready level
- `acpt_pulse` out NUM_CH: one-cycle registered accept event pulse
- `busy` out NUM_CH: channel is in WAIT
- `timeout` out NUM_CH: channel is in TOUT
- `stray_acpt` out NUM_CH: one-cycle pulse on an accept event outside WAIT

## Operation
- Per channel, the following are registered: rdy sync chain `rs[0..SYNC_STAGES-1]`, acpt sync chain `as[0..SYNC_STAGES-1]`, history flops `rs_d` and `as_d`, FSM state, and a TIMEOUT_W-bit counter `cnt`.
- `rdy_out` = `rs[SYNC_STAGES-1]`.
- Ready rise: `rs_last & ~rs_d`. Ready fall: `~rs_last & rs_d`.
- Accept event per PULSE_MODE:
  - mode 0: `as_last & ~as_d`
  - mode 1: `~as_last & as_d`
  - mode 2: `as_last ^ as_d`
- `acpt_pulse` is registered from the accept event and asserts for every event, regardless of FSM state.
- FSM states: IDLE, WAIT, TOUT.
  - IDLE -> WAIT on ready rise; `cnt` <= 0.
  - WAIT -> IDLE on accept event (transaction complete).
  - WAIT -> IDLE on ready fall (abort, no flag).
  - WAIT: `cnt` increments each cycle. If `timeout_limit != 0` and `cnt == timeout_limit - 1`, next state is TOUT.
  - TOUT -> IDLE when `rdy_out` is 0. A later accept event in TOUT gives a pulse plus `stray_acpt`; the state stays TOUT.
- `busy` = (state == WAIT). `timeout` = (state == TOUT). Both are decoded from registered state.
- `stray_acpt` registers (accept event & state != WAIT).
- Priority within one cycle, highest first: accept event, ready fall, timeout.
- `cnt` saturates at all-ones. Counting stops in IDLE and TOUT.
- Channels are fully independent. No cross-channel arbitration.
- `timeout_limit` changes while a channel is in WAIT take effect on the next compare. `cnt` is not reset.

## Timing
- Reset: every sync and history flop is 0, FSMs are IDLE, `cnt` = 0.
- Reset values of outputs: `rdy_out`, `acpt_pulse`, `busy`, `timeout` and `stray_acpt` are all 0.
- Reset takes effect at the first `clk` edge with `rst` = 1, including mid-transaction. No pulse or stray flag is generated on the first edge after release: the history flops reset to 0 together with the chains.
- Input sampled at edge k:
  - `rdy_out` reflects it after edge k+SYNC_STAGES-1.
  - `busy` asserts after edge k+SYNC_STAGES.
  - `acpt_pulse` and `stray_acpt` assert after edge k+SYNC_STAGES and stay high for exactly one cycle.
- Timeout: `timeout` asserts exactly `timeout_limit` cycles after `busy` first asserts, provided no event intervenes.
- Back-to-back events: with an input toggling every 2 cycles in mode 2, each event produces a separate pulse with no merging. Events narrower than one cycle are not guaranteed.

## Test plan
- Reset check: hold `rst` 3 cycles with `rdy_in`/`acpt_in` = all-ones, release. Required: all outputs 0 during reset. After release, `rdy_out` = all-ones after SYNC_STAGES edges. `busy` = 0xF at the next edge.
- Normal transaction (SYNC_STAGES=2, mode 0, limit 10): raise `rdy_in[0]` at edge 0 -> `busy[0]` high after edge 2. Raise `acpt_in[0]` at edge 5 -> `acpt_pulse[0]` high for one cycle after edge 7 and `busy[0]` low after edge 7.
- Timeout (limit 4): raise `rdy_in[1]`, never accept -> `timeout[1]` high 4 cycles after `busy[1]`. Drop `rdy_in[1]` -> `timeout[1]` clears SYNC_STAGES+1 edges later.
- Stray and mode 2: in IDLE, toggle `acpt_in[2]` 0->1->0 with 3 cycles between -> two `acpt_pulse[2]` pulses and two `stray_acpt[2]` pulses. Repeat with mode 0 -> one of each.
- Simultaneous events: in WAIT, make the accept event land on the same cycle the timeout compare hits -> the FSM returns to IDLE, `timeout` stays 0, `acpt_pulse` = 1.
- Reset mid-WAIT: assert `rst` while `busy[3]` = 1 and `cnt` = 7 -> after that edge, `busy[3]` = 0 and no pulse is emitted after release.

Source files
------------

// File: rtl/handshake_sync_bank_if.sv
// Ready/accept handshake bundle for handshake_sync_bank: async levels in, synchronised status out.
// master drives the asynchronous levels and limit; slave is the synchroniser bank.
interface handshake_sync_bank_if #(
  parameter int NUM_CH    = 4,
  parameter int TIMEOUT_W = 8
);
  logic [NUM_CH-1:0]    rdy_in;
  logic [NUM_CH-1:0]    acpt_in;
  logic [TIMEOUT_W-1:0] timeout_limit;
  logic [NUM_CH-1:0]    rdy_out;
  logic [NUM_CH-1:0]    acpt_pulse;
  logic [NUM_CH-1:0]    busy;
  logic [NUM_CH-1:0]    timeout;
  logic [NUM_CH-1:0]    stray_acpt;

  modport master (
    output rdy_in, acpt_in, timeout_limit,
    input  rdy_out, acpt_pulse, busy, timeout, stray_acpt
  );

  modport slave (
    input  rdy_in, acpt_in, timeout_limit,
    output rdy_out, acpt_pulse, busy, timeout, stray_acpt
  );
endinterface

// File: rtl/handshake_sync_bank.sv
// Per-channel ready/accept synchroniser with IDLE/WAIT/TOUT transaction supervision.
// Latency: SYNC_STAGES edges from input sample to busy/pulse; no backpressure, every event is reported.
module handshake_sync_bank #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_MODE  = 0,
  parameter int TIMEOUT_W   = 8
) (
  input logic                  clk,
  input logic                  rst,
  handshake_sync_bank_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_TOUT = 2'd2;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] rs;
    logic [SYNC_STAGES-1:0] as;
    logic                   rs_d;
    logic                   as_d;
    logic                   pulse_q;
    logic                   stray_q;
    logic [1:0]             state;
    logic [TIMEOUT_W-1:0]   cnt;
    logic                   rs_last;
    logic                   as_last;
    logic                   rdy_rise;
    logic                   rdy_fall;
    logic                   acpt_ev;
    logic                   limit_hit;

    assign rs_last  = rs[SYNC_STAGES-1];
    assign as_last  = as[SYNC_STAGES-1];
    assign rdy_rise = rs_last & ~rs_d;
    assign rdy_fall = ~rs_last & rs_d;

    if (PULSE_MODE == 2) begin : g_both
      assign acpt_ev = as_last ^ as_d;
    end else if (PULSE_MODE == 1) begin : g_fall
      assign acpt_ev = ~as_last & as_d;
    end else begin : g_rise
      assign acpt_ev = as_last & ~as_d;
    end

    // Limit is read live, so a change during WAIT applies at the next compare.
    assign limit_hit = (bus.timeout_limit != '0) &&
                       (cnt == bus.timeout_limit - TIMEOUT_W'(1));

    always_ff @(posedge clk) begin
      if (rst) begin
        rs      <= '0;
        as      <= '0;
        rs_d    <= 1'b0;
        as_d    <= 1'b0;
        pulse_q <= 1'b0;
        stray_q <= 1'b0;
        state   <= ST_IDLE;
        cnt     <= '0;
      end else begin
        rs      <= {rs[SYNC_STAGES-2:0], bus.rdy_in[c]};
        as      <= {as[SYNC_STAGES-2:0], bus.acpt_in[c]};
        rs_d    <= rs_last;
        as_d    <= as_last;
        pulse_q <= acpt_ev;
        stray_q <= acpt_ev & (state != ST_WAIT);
        case (state)
          ST_IDLE: begin
            if (rdy_rise) begin
              state <= ST_WAIT;
              cnt   <= '0;
            end
          end
          ST_WAIT: begin
            if (cnt != '1) cnt <= cnt + TIMEOUT_W'(1);
            // Accept wins over abort, abort wins over timeout.
            if (acpt_ev || rdy_fall) state <= ST_IDLE;
            else if (limit_hit)      state <= ST_TOUT;
          end
          ST_TOUT: begin
            if (!rs_last) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end

    assign bus.rdy_out[c]    = rs_last;
    assign bus.acpt_pulse[c] = pulse_q;
    assign bus.stray_acpt[c] = stray_q;
    assign bus.busy[c]       = (state == ST_WAIT);
    assign bus.timeout[c]    = (state == ST_TOUT);
  end
endmodule

// File: tb/tb_handshake_sync_bank.sv
// Bench for handshake_sync_bank: a rising-edge and a both-edge instance share stimulus
// and are compared every cycle against a queue-based transaction model.
module tb_handshake_sync_bank;
  localparam int NCH  = 4;
  localparam int SS   = 2;
  localparam int TW   = 8;
  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_TOUT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NCH-1:0] rdy_drv  = '0;
  logic [NCH-1:0] acpt_drv = '0;
  logic [TW-1:0]  lim      = 8'd10;

  handshake_sync_bank_if #(.NUM_CH(NCH), .TIMEOUT_W(TW)) if0 ();
  handshake_sync_bank_if #(.NUM_CH(NCH), .TIMEOUT_W(TW)) if2 ();

  assign if0.rdy_in        = rdy_drv;
  assign if0.acpt_in       = acpt_drv;
  assign if0.timeout_limit = lim;
  assign if2.rdy_in        = rdy_drv;
  assign if2.acpt_in       = acpt_drv;
  assign if2.timeout_limit = lim;

  handshake_sync_bank #(.NUM_CH(NCH), .SYNC_STAGES(SS), .PULSE_MODE(0), .TIMEOUT_W(TW))
    dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  handshake_sync_bank #(.NUM_CH(NCH), .SYNC_STAGES(SS), .PULSE_MODE(2), .TIMEOUT_W(TW))
    dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: input history queues (newest first) plus per-instance transaction state.
  bit             rq [NCH][$];
  bit             aq [NCH][$];
  int             st  [2][NCH];
  int             age [2][NCH];
  logic [NCH-1:0] m_rdy;
  logic [NCH-1:0] m_pulse [2];
  logic [NCH-1:0] m_stray [2];
  logic [NCH-1:0] m_busy  [2];
  logic [NCH-1:0] m_tout  [2];

  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      if (rst) begin
        rq[c] = {};
        aq[c] = {};
        for (int k = 0; k < SS + 2; k++) begin
          rq[c].push_back(1'b0);
          aq[c].push_back(1'b0);
        end
      end else begin
        rq[c].push_front(rdy_drv[c]);
        void'(rq[c].pop_back());
        aq[c].push_front(acpt_drv[c]);
        void'(aq[c].pop_back());
      end
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          st[i][c]      = M_IDLE;
          age[i][c]     = 0;
          m_pulse[i][c] = 1'b0;
          m_stray[i][c] = 1'b0;
        end else begin
          // Levels seen by the channel this edge: sampled SS and SS+1 edges ago.
          bit cur, prev, ac, ap, ev;
          cur  = rq[c][SS];
          prev = rq[c][SS+1];
          ac   = aq[c][SS];
          ap   = aq[c][SS+1];
          ev   = (i == 0) ? (ac && !ap) : (ac != ap);
          m_pulse[i][c] = ev;
          m_stray[i][c] = ev && (st[i][c] != M_WAIT);
          case (st[i][c])
            M_IDLE: if (cur && !prev) begin st[i][c] = M_WAIT; age[i][c] = 0; end
            M_WAIT: begin
              if (ev || (!cur && prev)) st[i][c] = M_IDLE;
              else if (lim != 0 && age[i][c] == int'(lim) - 1) st[i][c] = M_TOUT;
              if (age[i][c] < (1 << TW) - 1) age[i][c]++;
            end
            default: if (!cur) st[i][c] = M_IDLE;
          endcase
        end
        m_busy[i][c] = (st[i][c] == M_WAIT);
        m_tout[i][c] = (st[i][c] == M_TOUT);
      end
      m_rdy[c] = rst ? 1'b0 : rq[c][SS-1];
    end
  endtask

  task automatic compare_all();
    check_eq("m0.rdy_out",    if0.rdy_out,    m_rdy);
    check_eq("m0.acpt_pulse", if0.acpt_pulse, m_pulse[0]);
    check_eq("m0.stray_acpt", if0.stray_acpt, m_stray[0]);
    check_eq("m0.busy",       if0.busy,       m_busy[0]);
    check_eq("m0.timeout",    if0.timeout,    m_tout[0]);
    check_eq("m2.rdy_out",    if2.rdy_out,    m_rdy);
    check_eq("m2.acpt_pulse", if2.acpt_pulse, m_pulse[1]);
    check_eq("m2.stray_acpt", if2.stray_acpt, m_stray[1]);
    check_eq("m2.busy",       if2.busy,       m_busy[1]);
    check_eq("m2.timeout",    if2.timeout,    m_tout[1]);
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge, then caller drives.
  task automatic cycle(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
    end
  endtask

  initial begin
    int p0, p2, s0, s2;

    // Reset with all inputs high.
    rdy_drv  = '1;
    acpt_drv = '1;
    lim      = 8'd10;
    rst      = 1'b1;
    cycle(3);
    check_eq("rst.outs_zero", {if0.rdy_out, if0.busy, if0.acpt_pulse, if0.timeout}, 32'h0);
    rst = 1'b0;
    cycle(SS);
    check_eq("rst.rdy_out_ones", if0.rdy_out, 32'hF);
    cycle(1);
    check_eq("rst.busy_ones", if0.busy, 32'hF);
    rdy_drv  = '0;
    acpt_drv = '0;
    cycle(8);

    // Normal transaction on channel 0.
    rdy_drv[0] = 1'b1;
    cycle(3);
    check_eq("txn.busy_on", if0.busy[0], 32'h1);
    cycle(2);
    acpt_drv[0] = 1'b1;
    cycle(3);
    check_eq("txn.pulse", if0.acpt_pulse[0], 32'h1);
    check_eq("txn.busy_off", if0.busy[0], 32'h0);
    cycle(1);
    check_eq("txn.pulse_1cyc", if0.acpt_pulse[0], 32'h0);
    rdy_drv  = '0;
    acpt_drv = '0;
    cycle(6);

    // Timeout on channel 1, then clear by dropping ready.
    lim = 8'd4;
    rdy_drv[1] = 1'b1;
    cycle(3);
    check_eq("tout.busy_on", if0.busy[1], 32'h1);
    cycle(3);
    check_eq("tout.not_yet", if0.timeout[1], 32'h0);
    cycle(1);
    check_eq("tout.on", if0.timeout[1], 32'h1);
    rdy_drv[1] = 1'b0;
    cycle(SS);
    check_eq("tout.held", if0.timeout[1], 32'h1);
    cycle(1);
    check_eq("tout.cleared", if0.timeout[1], 32'h0);
    cycle(4);

    // Stray accepts on idle channel 2: both-edge sees two, rising-edge sees one.
    p0 = 0; p2 = 0; s0 = 0; s2 = 0;
    for (int ph = 0; ph < 2; ph++) begin
      acpt_drv[2] = (ph == 0);
      for (int k = 0; k < 4; k++) begin
        cycle(1);
        p0 += int'(if0.acpt_pulse[2]);
        p2 += int'(if2.acpt_pulse[2]);
        s0 += int'(if0.stray_acpt[2]);
        s2 += int'(if2.stray_acpt[2]);
      end
    end
    cycle(4);
    check_eq("stray.m2_pulses", p2, 2);
    check_eq("stray.m2_strays", s2, 2);
    check_eq("stray.m0_pulses", p0, 1);
    check_eq("stray.m0_strays", s0, 1);

    // Accept event on the same edge as the timeout compare, channel 3.
    lim = 8'd6;
    rdy_drv[3] = 1'b1;
    cycle(6);
    acpt_drv[3] = 1'b1;
    cycle(SS + 1);
    check_eq("simul.pulse", if0.acpt_pulse[3], 32'h1);
    check_eq("simul.busy", if0.busy[3], 32'h0);
    check_eq("simul.timeout", if0.timeout[3], 32'h0);
    cycle(1);
    check_eq("simul.timeout_later", if0.timeout[3], 32'h0);
    rdy_drv  = '0;
    acpt_drv = '0;
    cycle(6);

    // Reset while channel 3 is mid-WAIT with cnt = 7.
    lim = 8'd20;
    rdy_drv[3] = 1'b1;
    cycle(SS + 1 + 7);
    check_eq("rstw.busy_before", if0.busy[3], 32'h1);
    rst = 1'b1;
    cycle(1);
    check_eq("rstw.busy_after", if0.busy[3], 32'h0);
    rst = 1'b0;
    p0 = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(1);
      p0 += int'(if0.acpt_pulse[3]) + int'(if2.acpt_pulse[3]);
    end
    check_eq("rstw.no_pulse", p0, 0);
    rdy_drv = '0;
    cycle(6);

    // Randomised traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 9) == 0) rdy_drv[c]  = ~rdy_drv[c];
        if ($urandom_range(0, 7) == 0) acpt_drv[c] = ~acpt_drv[c];
      end
      if ($urandom_range(0, 149) == 0) lim = 8'($urandom_range(0, 12));
      rst = ($urandom_range(0, 599) == 0);
      cycle(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
